// File: rtl/ctrl_pipe_if.sv
// Control-pipe bundle: decode-side inputs, per-stage controls and per-stage state readback.
// Latency: none, signal grouping only.
// Backpressure: carried by stall, one bit per stage; there is no ready/valid return path.
interface ctrl_pipe_if #(
  parameter int W      = 16,
  parameter int STAGES = 3,
  parameter int CW     = 16
);
  logic                   in_valid;
  logic [W-1:0]           in_word;
  logic [STAGES-1:0]      stall;
  logic [STAGES-1:0]      flush;
  logic [STAGES-2:0]      kill;
  logic [STAGES-1:0]      out_valid;
  logic [STAGES*W-1:0]    out_word;
  logic                   stall_err;
  logic [CW-1:0]          bubble_cnt;

  // Upstream side: decoder and hazard unit drive controls and observe stage state.
  modport master (
    output in_valid, in_word, stall, flush, kill,
    input  out_valid, out_word, stall_err, bubble_cnt
  );

  // Pipe side: consumes controls and publishes registered stage state.
  modport slave (
    input  in_valid, in_word, stall, flush, kill,
    output out_valid, out_word, stall_err, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries decoded control words through STAGES registers with per-stage stall/flush and boundary kill masking.
// Latency: a word accepted at edge n sits in stage k after edge n+k when nothing stalls.
// Backpressure: stall[i] holds stage i; the stage below a held one takes a bubble; a stalled stage 0 relies on decode holding in_word.
module ctrl_pipe #(
  parameter int           W         = 16,
  parameter int           STAGES    = 3,
  parameter logic [W-1:0] KILL_MASK = W'(1),
  parameter int           CW        = 16
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  logic [STAGES-1:0]        validQ;
  logic [STAGES-1:0]        validD;
  logic [STAGES-1:0][W-1:0] wordQ;
  logic [STAGES-1:0][W-1:0] wordD;
  logic                     stallErrQ;
  logic                     stallViol;
  logic [CW-1:0]            bubbleCntQ;

  // Next state per stage: flush beats stall, stall beats bubble insertion, otherwise load from the stage above.
  always_comb begin
    validD = validQ;
    wordD  = wordQ;

    if (bus.flush[0]) begin
      validD[0] = 1'b0;
      wordD[0]  = '0;
    end else if (!bus.stall[0]) begin
      validD[0] = bus.in_valid;
      wordD[0]  = bus.in_word;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (bus.flush[i]) begin
        validD[i] = 1'b0;
        wordD[i]  = '0;
      end else if (!bus.stall[i]) begin
        if (bus.stall[i-1]) begin
          // Upstream is held, so nothing crosses this boundary this cycle.
          validD[i] = 1'b0;
          wordD[i]  = '0;
        end else begin
          // Kill only touches the word actually crossing the boundary.
          validD[i] = validQ[i-1];
          wordD[i]  = wordQ[i-1] & ~(bus.kill[i-1] ? KILL_MASK : '0);
        end
      end
    end

    // A bubble never carries stale control bits into the datapath.
    for (int i = 0; i < STAGES; i++) begin
      if (!validD[i]) begin
        wordD[i] = '0;
      end
    end
  end

  // A held stage whose upstream neighbour keeps moving would be overwritten: flag it.
  always_comb begin
    stallViol = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      if (bus.stall[i] && !bus.stall[i-1] && !bus.flush[i-1]) begin
        stallViol = 1'b1;
      end
    end
  end

  // Stage registers, sticky ordering flag and saturating last-stage bubble counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      validQ     <= '0;
      wordQ      <= '0;
      stallErrQ  <= 1'b0;
      bubbleCntQ <= '0;
    end else begin
      validQ    <= validD;
      wordQ     <= wordD;
      stallErrQ <= stallErrQ | stallViol;
      if (!validQ[STAGES-1] && (bubbleCntQ != {CW{1'b1}})) begin
        bubbleCntQ <= bubbleCntQ + CW'(1);
      end
    end
  end

  assign bus.out_valid  = validQ;
  assign bus.out_word   = wordQ;
  assign bus.stall_err  = stallErrQ;
  assign bus.bubble_cnt = bubbleCntQ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (W=8, STAGES=3, KILL_MASK=8'h01, CW=4).
// Stimulus pushes the hand-computed state expected after each edge; a monitor pops and compares.
// Bounded by a watchdog so the run always reaches its summary line.
module tb_ctrl_pipe;

  localparam int W = 8;
  localparam int STAGES = 3;
  localparam int CW = 4;

  typedef struct {
    int          tgt;
    string       nm;
    logic [2:0]  v;
    logic [23:0] w;
    logic        err;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;
  exp_t q[$];

  ctrl_pipe_if #(.W(W), .STAGES(STAGES), .CW(CW)) bus ();

  ctrl_pipe #(
    .W(W), .STAGES(STAGES), .KILL_MASK(8'h01), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: after each edge, compare the DUT against every expectation targeted at that edge.
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.tgt != cyc) begin
        fails++;
        $display("FAIL %s: expectation for edge %0d seen at edge %0d", e.nm, e.tgt, cyc);
      end
      tests++;
      if (bus.out_valid !== e.v) begin
        fails++;
        $display("FAIL %s.valid edge %0d: got %b want %b", e.nm, cyc, bus.out_valid, e.v);
      end
      tests++;
      if (bus.out_word !== e.w) begin
        fails++;
        $display("FAIL %s.word edge %0d: got %h want %h", e.nm, cyc, bus.out_word, e.w);
      end
      tests++;
      if (bus.stall_err !== e.err) begin
        fails++;
        $display("FAIL %s.err edge %0d: got %b want %b", e.nm, cyc, bus.stall_err, e.err);
      end
      tests++;
      if (bus.bubble_cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s.cnt edge %0d: got %h want %h", e.nm, cyc, bus.bubble_cnt, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs, queue the state expected after the coming edge, move to next negedge.
  task automatic step(input string nm, input logic r, input logic iv, input logic [7:0] iw,
                      input logic [2:0] st, input logic [2:0] fl, input logic [1:0] kl,
                      input logic [2:0] ev, input logic [7:0] e2, input logic [7:0] e1,
                      input logic [7:0] e0, input logic eerr, input logic [3:0] ecnt);
    exp_t e;
    rst          = r;
    bus.in_valid = iv;
    bus.in_word  = iw;
    bus.stall    = st;
    bus.flush    = fl;
    bus.kill     = kl;
    e.tgt = cyc + 1;
    e.nm  = nm;
    e.v   = ev;
    e.w   = {e2, e1, e0};
    e.err = eerr;
    e.cnt = ecnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: run exceeded time limit, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.stall    = '0;
    bus.flush    = '0;
    bus.kill     = '0;

    //    name        rst iv  word   stall   flush   kill   valid   s2     s1     s0     err  cnt
    step("rst0",      0, 1, 8'hFF, 3'b000, 3'b000, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd0);
    step("rst1",      0, 1, 8'hFF, 3'b000, 3'b000, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd0);
    step("fillA5",    1, 1, 8'hA5, 3'b000, 3'b000, 2'b00, 3'b001, 8'h00, 8'h00, 8'hA5, 0, 4'd1);
    step("fill3C",    1, 1, 8'h3C, 3'b000, 3'b000, 2'b00, 3'b011, 8'h00, 8'hA5, 8'h3C, 0, 4'd2);
    step("fill81",    1, 1, 8'h81, 3'b000, 3'b000, 2'b00, 3'b111, 8'hA5, 8'h3C, 8'h81, 0, 4'd3);
    step("fill11",    1, 1, 8'h11, 3'b000, 3'b000, 2'b00, 3'b111, 8'h3C, 8'h81, 8'h11, 0, 4'd3);
    step("fill22",    1, 1, 8'h22, 3'b000, 3'b000, 2'b00, 3'b111, 8'h81, 8'h11, 8'h22, 0, 4'd3);
    step("fill33",    1, 1, 8'h33, 3'b000, 3'b000, 2'b00, 3'b111, 8'h11, 8'h22, 8'h33, 0, 4'd3);
    step("stall1",    1, 1, 8'h44, 3'b011, 3'b000, 2'b00, 3'b011, 8'h00, 8'h22, 8'h33, 0, 4'd3);
    step("stall2",    1, 1, 8'h44, 3'b011, 3'b000, 2'b00, 3'b011, 8'h00, 8'h22, 8'h33, 0, 4'd4);
    step("release",   1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 3'b110, 8'h22, 8'h33, 8'h00, 0, 4'd5);
    step("drain",     1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 3'b100, 8'h33, 8'h00, 8'h00, 0, 4'd5);
    step("send07",    1, 1, 8'h07, 3'b000, 3'b000, 2'b00, 3'b001, 8'h00, 8'h00, 8'h07, 0, 4'd5);
    step("kill0",     1, 1, 8'h0F, 3'b000, 3'b000, 2'b01, 3'b011, 8'h00, 8'h06, 8'h0F, 0, 4'd6);
    step("killStall", 1, 0, 8'h00, 3'b011, 3'b000, 2'b01, 3'b011, 8'h00, 8'h06, 8'h0F, 0, 4'd7);
    step("flushPri",  1, 0, 8'h00, 3'b011, 3'b010, 2'b00, 3'b001, 8'h00, 8'h00, 8'h0F, 0, 4'd8);
    step("send55",    1, 1, 8'h55, 3'b000, 3'b000, 2'b00, 3'b011, 8'h00, 8'h0F, 8'h55, 0, 4'd9);
    step("ordViol",   1, 1, 8'h66, 3'b100, 3'b000, 2'b00, 3'b011, 8'h00, 8'h55, 8'h66, 1, 4'd10);
    step("errSticky", 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 3'b110, 8'h55, 8'h66, 8'h00, 1, 4'd11);
    step("errClear",  0, 0, 8'h00, 3'b000, 3'b000, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      step("sat", 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00, 0,
           4'((k > 15) ? 15 : k));
    end
    step("sendAB",    1, 1, 8'hAB, 3'b000, 3'b000, 2'b00, 3'b001, 8'h00, 8'h00, 8'hAB, 0, 4'd15);
    step("midRst",    0, 1, 8'hCD, 3'b000, 3'b000, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 4'd0);

    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised pipeline carrier for decoded control words. The decoder output enters stage 0, and the word advances one stage per cycle through STAGES registered stages (E, M, W, ... in the MIPS core).
- Generalises fixed per-stage control registers with:
  - per-stage stall and flush;
  - per-boundary kill masking, which generalises overflow cancelling regwrite;
  - valid tracking;
  - a stall-ordering checker;
  - a saturating bubble counter.
- Sits between the decoder and the datapath and replaces the hand-built control stage registers.

Parameters:
- W, 16, control word width in bits (≥1).
- STAGES, 3, number of registered stages (≥2). Stage 0 is the first register after decode.
- KILL_MASK, {W{1'b0}} with bit 0 set (16'h0001), bits cleared in a word crossing a killed boundary.
- CW, 16, bubble counter width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, reset; synchronous, active-low (0 = reset).
- in_valid, in, 1, decode stage holds a valid instruction.
- in_word, in, W, decoded control word.
- stall, in, STAGES, stall[i]=1 holds stage i.
- flush, in, STAGES, flush[i]=1 clears stage i to a bubble.
- kill, in, STAGES-1, kill[i]=1 masks the word moving from stage i into stage i+1.
- out_valid, out, STAGES, valid bit per stage.
- out_word, out, STAGES*W, stage i word at [i*W +: W].
- stall_err, out, 1, sticky stall-ordering violation flag.
- bubble_cnt, out, CW, count of cycles with the last stage invalid.

Behaviour:
- **Reset** (rst=0 at a clock edge): all out_valid=0, all out_word=0, stall_err=0, bubble_cnt=0. Reset applied mid-operation discards all stages within the same edge.
- **Per-stage next state**, evaluated independently for each stage i, in this priority order:
  1. flush[i]=1: valid=0, word=0. Flush beats stall.
  2. stall[i]=1: hold valid and word.
  3. i>0 and stall[i-1]=1: insert a bubble (valid=0, word=0).
  4. Otherwise load from the source:
     - stage 0: valid=in_valid, word=in_word.
     - stage i>0: valid=out_valid[i-1], word=out_word[i-1] & ~(kill[i-1] ? KILL_MASK : 0).
- **Invalid words:** a loaded word with valid=0 is forced to 0. An out_word entry with out_valid=0 is always 0.
- **Latency:** a word accepted at edge n appears in stage k after edge n+k, when there are no stalls.
- **Kill:** affects only the word crossing that boundary. It is ignored if the destination stalls or flushes. KILL_MASK=0 disables kill entirely.
- **Stage 0 stall:** the upstream decode stage must hold in_word itself. ctrl_pipe does not buffer it.
- **Stall ordering:**
  - Legal pattern: stall[i]=1 implies stall[j]=1 for all j<i, unless flush[j]=1.
  - Violation: at an edge with rst=1, some i>0 has stall[i]=1, stall[i-1]=0 and flush[i-1]=0.
  - On violation, stall_err is set to 1 and stays 1 until reset.
  - Stage i-1 still updates per the priority rules, so its old content is overwritten (data loss is flagged, not prevented).
- **bubble_cnt:** at each edge with rst=1, increments when out_valid[STAGES-1]=0 as sampled before the edge. It saturates at 2^CW-1 and does not wrap.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Simultaneous events:**
  - flush[i] together with stall[i+1]: stage i+1 holds, stage i clears.
  - flush[i] together with stall[i-1]: stage i clears (flush has priority over bubble insertion; result identical).

Test Plan (W=8, STAGES=3, KILL_MASK=8'h01, CW=4):
- **Reset:** drive rst=0 for 2 cycles with in_valid=1, in_word=8'hFF → out_valid=3'b000, out_word=0, bubble_cnt=0, stall_err=0. Release rst and feed 8'hA5,8'h3C,8'h81 on consecutive cycles → after the 3rd edge, stage2=8'hA5, stage1=8'h3C, stage0=8'h81, out_valid=3'b111.
- **Stall/bubble:** with the pipe full of 8'h11,8'h22,8'h33 (stage2..0), hold stall=3'b011 for 2 cycles → stages 0 and 1 hold 8'h33 and 8'h22; stage2 shows a bubble (valid 0, word 0) for both cycles; bubble_cnt increments by 2 once those bubbles are sampled.
- **Kill:** send 8'h07 and assert kill[0]=1 when it moves from stage 0 to 1 → stage1 word=8'h06. With stall[1]=1 during a kill[0], stage1 holds its old word unchanged.
- **Flush priority:** flush=3'b010 together with stall=3'b011 → stage1 becomes valid 0, word 0; stage0 holds; stall_err stays 0.
- **Ordering violation:** stall=3'b100 with flush=0 → stall_err=1 after the edge, and stage1 is overwritten by the stage0 word. stall_err remains 1 after stall is deasserted, and clears only on rst=0.
- **Saturation:** keep in_valid=0 for 20 cycles after reset → bubble_cnt reaches 4'hF and stays there. Assert rst=0 mid-stream → all outputs back to reset values on that edge.
